// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed common-anode 7-segment scan controller with frame-synchronous double buffering.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYCLES  = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_tick,
  output logic                    pending
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_act, r_shd;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_shd_dp, r_an;
  logic [3:0]              r_bcd;
  logic                    r_dp, r_tick, r_pend;
  logic                    w_adv, w_wrap, w_blk;
  logic [CW-1:0]           w_cnt_nx;
  logic [IW-1:0]           w_idx_nx;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [3:0]              w_dig;
  assign w_adv    = r_cnt == CW'(SCAN_DIV - 1);
  assign w_wrap   = w_adv && r_idx == IW'(NUM_DIGITS - 1);
  assign w_cnt_nx = w_adv ? '0 : r_cnt + 1'b1;
  assign w_idx_nx = !w_adv ? r_idx : w_wrap ? '0 : r_idx + 1'b1;
  assign w_dig    = r_act[{r_idx, 2'b00} +: 4];
  // w_lz[k]: every active digit at position k and above is zero
  always_comb begin
    w_lz = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      w_lz[k] = (r_act >> (4 * k)) == '0;
  end
  assign w_blk = BLANK_LEADING != 0 && r_idx != '0 && w_lz[r_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_act    <= '0;
      r_shd    <= '0;
      r_act_dp <= '0;
      r_shd_dp <= '0;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
      r_an     <= '1;
      r_bcd    <= 4'hF;
      r_dp     <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nx;
      r_idx  <= w_idx_nx;
      // pre-decoded so the registered tick lands in the wrap cycle itself
      r_tick <= w_cnt_nx == CW'(SCAN_DIV - 1) && w_idx_nx == IW'(NUM_DIGITS - 1);
      if (load && w_wrap) begin
        r_act    <= bcd_in;
        r_act_dp <= dp_in;
        r_pend   <= 1'b0;
      end else if (w_wrap && r_pend) begin
        r_act    <= r_shd;
        r_act_dp <= r_shd_dp;
        r_pend   <= 1'b0;
      end else if (load) begin
        r_shd    <= bcd_in;
        r_shd_dp <= dp_in;
        r_pend   <= 1'b1;
      end
      r_an  <= (32'(r_cnt) < BLANK_CYCLES) ? '1 : ~(NUM_DIGITS'(1) << r_idx);
      r_bcd <= w_blk ? 4'hF : w_dig;
      r_dp  <= ~r_act_dp[r_idx];
    end
  end
  assign an         = r_an;
  assign bcd_out    = r_bcd;
  assign dp         = r_dp;
  assign frame_tick = r_tick;
  assign pending    = r_pend;
endmodule
